regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 93 +++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with writeback bypass and a pending-write scoreboard.
// x0 is hardwired to zero; counters track pending registers and committed writebacks.
module regfile_mp #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned NRD     = 2,
    localparam int unsigned AW     = $clog2(REG_NUM)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   rs_addr_i,
    output logic [NRD*XLEN-1:0] rs_data_o,
    output logic [NRD-1:0]      rs_busy_o,
    input  logic                rd_we_i,
    input  logic [AW-1:0]       rd_addr_i,
    input  logic [XLEN-1:0]     rd_data_i,
    input  logic                iss_we_i,
    input  logic [AW-1:0]       iss_addr_i,
    output logic [AW:0]         busy_cnt_o,
    output logic [31:0]         wr_cnt_o
);

    logic [XLEN-1:0]    regs_q [REG_NUM];
    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [AW:0]        busy_cnt_q, busy_pop;
    logic [31:0]        wr_cnt_q, wr_cnt_d;
    logic               wr_en;

    assign wr_en = rd_we_i && (rd_addr_i != '0);

    // Storage; entry 0 is cleared on reset and never written, so it always reads zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd_addr_i] <= rd_data_i;
        end
    end

    // Issue is applied after writeback so a same-cycle issue keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (rd_we_i) begin
            busy_d[rd_addr_i] = 1'b0;
        end
        if (iss_we_i && (iss_addr_i != '0)) begin
            busy_d[iss_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_pop = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            busy_pop = busy_pop + (AW+1)'(busy_q[i]);
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    // busy_cnt lags busy by one edge: it registers the population of the current busy set.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            wr_cnt_q   <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_pop;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign busy_cnt_o = busy_cnt_q;
    assign wr_cnt_o   = wr_cnt_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        assign ra  = rs_addr_i[k*AW +: AW];
        assign hit = rd_we_i && (rd_addr_i == ra);
        assign rs_data_o[k*XLEN +: XLEN] = (hit && wr_en) ? rd_data_i : regs_q[ra];
        assign rs_busy_o[k] = busy_q[ra] & ~hit;
    end

endmodule
